div_issue_queue: RTL and testbench

- Front end and result collector for the iterative divider in the integer pipeline; it drives the divider's start side and consumes its completion side.
- Buffers divide uops from dispatch in a small FIFO and launches one at a time when the divider reports ready.
- Captures the completion pulse and holds the {remainder, quotient} result until the writeback port accepts it.
- Handles pipeline flush, including draining a divide already in flight, since the divider cannot be killed.

---
 rtl/div_issue_queue_pkg.sv | 23 ++
 rtl/div_issue_queue_uop_fifo.sv | 43 ++++
 rtl/div_issue_queue.sv | 143 ++++++++++++++
 tb/tb_div_issue_queue.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_queue_pkg.sv
// Shared types for the divider issue queue: FSM states, uop payload and tag widths.
package div_issue_queue_pkg;

  localparam int unsigned LG_ROB_ENTRIES      = 6;
  localparam int unsigned LG_HILO_PRF_ENTRIES = 2;
  localparam int unsigned DIV_LG_W            = 5;
  localparam int unsigned DIV_W               = 1 << DIV_LG_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DIV = 2'd1,
    HOLD_WB  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0]               srcA;
    logic [DIV_W-1:0]               srcB;
    logic                           is_signed;
    logic [LG_ROB_ENTRIES-1:0]      rob_ptr;
    logic [LG_HILO_PRF_ENTRIES-1:0] hilo_ptr;
  } div_uop_t;

endpackage

// File: rtl/div_issue_queue_uop_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a one-cycle clear.
module uop_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [LG_DEPTH:0] wr_ptr;
  logic [LG_DEPTH:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[LG_DEPTH-1:0]] <= push_data;
  end

  // Same slot index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LG_DEPTH] != rd_ptr[LG_DEPTH]) &&
                 (wr_ptr[LG_DEPTH-1:0] == rd_ptr[LG_DEPTH-1:0]);
  assign head  = mem[rd_ptr[LG_DEPTH-1:0]];

endmodule

// File: rtl/div_issue_queue.sv
// Divider front end: queues divide uops, launches one at a time, holds the result for writeback.
module div_issue_queue
  import div_issue_queue_pkg::*;
#(
  parameter int unsigned LG_W     = DIV_LG_W,
  parameter int unsigned LG_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(1<<LG_W)-1:0]           in_srcA,
  input  logic [(1<<LG_W)-1:0]           in_srcB,
  input  logic                           in_signed,
  input  logic [LG_ROB_ENTRIES-1:0]      in_rob_ptr,
  input  logic [LG_HILO_PRF_ENTRIES-1:0] in_hilo_ptr,
  input  logic                           flush,
  output logic                           div_start,
  output logic [(1<<LG_W)-1:0]           div_srcA,
  output logic [(1<<LG_W)-1:0]           div_srcB,
  output logic                           div_signed,
  output logic [LG_ROB_ENTRIES-1:0]      div_rob_ptr,
  output logic [LG_HILO_PRF_ENTRIES-1:0] div_hilo_ptr,
  input  logic                           div_ready,
  input  logic                           div_complete,
  input  logic [2*(1<<LG_W)-1:0]         div_y,
  input  logic [LG_ROB_ENTRIES-1:0]      div_rob_ptr_in,
  input  logic [LG_HILO_PRF_ENTRIES-1:0] div_hilo_ptr_in,
  output logic                           wb_valid,
  input  logic                           wb_ack,
  output logic [(1<<LG_W)-1:0]           wb_hi,
  output logic [(1<<LG_W)-1:0]           wb_lo,
  output logic [LG_ROB_ENTRIES-1:0]      wb_rob_ptr,
  output logic [LG_HILO_PRF_ENTRIES-1:0] wb_hilo_ptr,
  output logic                           busy
);

  localparam int unsigned W = 1 << LG_W;

  state_t   state, state_nxt;
  logic     r_squash, squash_nxt;
  logic     capture;
  logic     push;
  logic     fifo_full, fifo_empty;
  div_uop_t in_uop, head_uop;
  logic [LG_ROB_ENTRIES-1:0] r_launch_rob;

  assign in_ready = !fifo_full && !flush && !reset;
  assign push     = in_valid && in_ready;

  always_comb begin
    in_uop           = '0;
    in_uop.srcA      = in_srcA;
    in_uop.srcB      = in_srcB;
    in_uop.is_signed = in_signed;
    in_uop.rob_ptr   = in_rob_ptr;
    in_uop.hilo_ptr  = in_hilo_ptr;
  end

  uop_fifo #(
    .WIDTH    ($bits(div_uop_t)),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (in_uop),
    .pop       (div_start),
    .head      (head_uop),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign div_srcA     = head_uop.srcA;
  assign div_srcB     = head_uop.srcB;
  assign div_signed   = head_uop.is_signed;
  assign div_rob_ptr  = head_uop.rob_ptr;
  assign div_hilo_ptr = head_uop.hilo_ptr;

  always_comb begin
    state_nxt  = state;
    squash_nxt = r_squash;
    div_start  = 1'b0;
    wb_valid   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && !fifo_empty && div_ready && !flush) begin
          div_start = 1'b1;
          state_nxt = WAIT_DIV;
        end
      end
      WAIT_DIV: begin
        // The divider cannot be killed, so a flush only marks the in-flight result for discard.
        if (div_complete) begin
          squash_nxt = 1'b0;
          state_nxt  = (r_squash || flush) ? IDLE : HOLD_WB;
          capture    = !(r_squash || flush);
        end else if (flush) begin
          squash_nxt = 1'b1;
        end
      end
      HOLD_WB: begin
        wb_valid = !reset;
        if (flush || wb_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      r_squash     <= 1'b0;
      wb_hi        <= '0;
      wb_lo        <= '0;
      wb_rob_ptr   <= '0;
      wb_hilo_ptr  <= '0;
      r_launch_rob <= '0;
    end else begin
      state    <= state_nxt;
      r_squash <= squash_nxt;
      if (capture) begin
        wb_hi       <= div_y[2*W-1:W];
        wb_lo       <= div_y[W-1:0];
        wb_rob_ptr  <= div_rob_ptr_in;
        wb_hilo_ptr <= div_hilo_ptr_in;
      end
      if (div_start) r_launch_rob <= head_uop.rob_ptr;
    end
  end

  assign busy = !reset && (!fifo_empty || (state != IDLE));

  a_complete_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) div_complete |-> (state == WAIT_DIV));

  a_returned_tag_matches: assert property (
    @(posedge clk) disable iff (reset)
    (div_complete && state == WAIT_DIV) |-> (div_rob_ptr_in == r_launch_rob));

endmodule

// File: tb/tb_div_issue_queue.sv
// Scoreboard bench for div_issue_queue with a behavioural divider and directed plus random stimulus.
module tb_div_issue_queue;
  import div_issue_queue_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           reset;
  logic                           in_valid, in_ready, in_signed;
  logic [W-1:0]                   in_srcA, in_srcB;
  logic [LG_ROB_ENTRIES-1:0]      in_rob_ptr;
  logic [LG_HILO_PRF_ENTRIES-1:0] in_hilo_ptr;
  logic                           flush;
  logic                           div_start, div_signed, div_ready, div_complete;
  logic [W-1:0]                   div_srcA, div_srcB;
  logic [LG_ROB_ENTRIES-1:0]      div_rob_ptr, div_rob_ptr_in;
  logic [LG_HILO_PRF_ENTRIES-1:0] div_hilo_ptr, div_hilo_ptr_in;
  logic [2*W-1:0]                 div_y;
  logic                           wb_valid, wb_ack, busy;
  logic [W-1:0]                   wb_hi, wb_lo;
  logic [LG_ROB_ENTRIES-1:0]      wb_rob_ptr;
  logic [LG_HILO_PRF_ENTRIES-1:0] wb_hilo_ptr;

  div_issue_queue #(.LG_W(5), .LG_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_srcA(in_srcA), .in_srcB(in_srcB),
    .in_signed(in_signed), .in_rob_ptr(in_rob_ptr), .in_hilo_ptr(in_hilo_ptr),
    .flush(flush),
    .div_start(div_start), .div_srcA(div_srcA), .div_srcB(div_srcB), .div_signed(div_signed),
    .div_rob_ptr(div_rob_ptr), .div_hilo_ptr(div_hilo_ptr), .div_ready(div_ready),
    .div_complete(div_complete), .div_y(div_y),
    .div_rob_ptr_in(div_rob_ptr_in), .div_hilo_ptr_in(div_hilo_ptr_in),
    .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_rob_ptr(wb_rob_ptr), .wb_hilo_ptr(wb_hilo_ptr), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int n_retired = 0;

  typedef struct {
    logic [W-1:0]                   hi;
    logic [W-1:0]                   lo;
    logic [LG_ROB_ENTRIES-1:0]      rob;
    logic [LG_HILO_PRF_ENTRIES-1:0] hilo;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event expected event within bound at %0t", name, $time);
  endtask

  function automatic logic [2*W-1:0] ref_div(logic [W-1:0] a, logic [W-1:0] b, logic sgn);
    logic signed [W-1:0] sq, sr;
    if (sgn) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Behavioural divider: variable latency, result returned with the launch tags.
  int   dv_lat_min = 3, dv_lat_max = 3, dv_cnt = 0;
  logic dv_busy = 1'b0, dv_hold = 1'b0;
  assign div_ready = !dv_busy && !dv_hold;

  initial begin
    logic l_go, l_rst;
    logic [2*W-1:0] l_y, p_y;
    logic [LG_ROB_ENTRIES-1:0] l_rob, p_rob;
    logic [LG_HILO_PRF_ENTRIES-1:0] l_hilo, p_hilo;
    div_complete = 1'b0; div_y = '0; div_rob_ptr_in = '0; div_hilo_ptr_in = '0;
    p_y = '0; p_rob = '0; p_hilo = '0;
    forever begin
      @(negedge clk);
      l_go = div_start; l_rst = reset;
      l_y = ref_div(div_srcA, div_srcB, div_signed);
      l_rob = div_rob_ptr; l_hilo = div_hilo_ptr;
      @(posedge clk); #1;
      div_complete = 1'b0;
      if (l_rst) begin
        dv_busy = 1'b0;
      end else if (l_go) begin
        dv_busy = 1'b1;
        dv_cnt = $urandom_range(dv_lat_max, dv_lat_min);
        p_y = l_y; p_rob = l_rob; p_hilo = l_hilo;
      end else if (dv_busy) begin
        if (dv_cnt <= 1) begin
          div_complete = 1'b1;
          div_y = p_y; div_rob_ptr_in = p_rob; div_hilo_ptr_in = p_hilo;
          dv_busy = 1'b0;
        end else begin
          dv_cnt--;
        end
      end
    end
  end

  // Issue side of the scoreboard: every accepted uop expects its quotient/remainder in order;
  // flush or reset squashes everything accepted so far.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset || flush) exp_q.delete();
      else if (in_valid && in_ready) begin
        {e.hi, e.lo} = ref_div(in_srcA, in_srcB, in_signed);
        e.rob = in_rob_ptr;
        e.hilo = in_hilo_ptr;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: retire results on accepted writeback and compare against the scoreboard.
  initial begin
    exp_t e;
    logic prev_v;
    logic [127:0] prev_data;
    prev_v = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wb_valid) check("no_launch_while_held", div_start, 0);
        if (prev_v) begin
          check("wb_held_valid", wb_valid, 1);
          check("wb_held_stable", {wb_hi, wb_lo, wb_rob_ptr, wb_hilo_ptr}, prev_data);
        end
        if (wb_valid && wb_ack && !flush) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected: got result rob=%0h expected none at %0t", wb_rob_ptr, $time);
          end else begin
            e = exp_q.pop_front();
            check("wb_lo", wb_lo, e.lo);
            check("wb_hi", wb_hi, e.hi);
            check("wb_rob_ptr", wb_rob_ptr, e.rob);
            check("wb_hilo_ptr", wb_hilo_ptr, e.hilo);
            n_retired++;
          end
        end
      end
      prev_v = wb_valid && !wb_ack && !flush && !reset;
      prev_data = {wb_hi, wb_lo, wb_rob_ptr, wb_hilo_ptr};
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sgn, int rob, int hilo);
    in_valid = 1'b1; in_srcA = a; in_srcB = b; in_signed = sgn;
    in_rob_ptr = LG_ROB_ENTRIES'(rob); in_hilo_ptr = LG_HILO_PRF_ENTRIES'(hilo);
  endtask

  task automatic wait_complete(string name);
    for (int i = 0; i < 100 && !div_complete; i++) begin next(); @(negedge clk); end
    if (!div_complete) timeout(name);
  endtask

  task automatic wait_wb(string name);
    for (int i = 0; i < 100 && !wb_valid; i++) begin next(); @(negedge clk); end
    if (!wb_valid) timeout(name);
  endtask

  task automatic wait_fire(string name);
    for (int i = 0; i < 100 && !(dv_busy && dv_cnt == 1); i++) begin next(); @(negedge clk); end
    if (!(dv_busy && dv_cnt == 1)) timeout(name);
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || busy || wb_valid); i++) begin
      next(); @(negedge clk);
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [W-1:0] a, b;
    logic sgn;
    reset = 1'b1; in_valid = 1'b0; in_srcA = '0; in_srcB = 32'd1; in_signed = 1'b0;
    in_rob_ptr = '0; in_hilo_ptr = '0; flush = 1'b0; wb_ack = 1'b1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_div_start", div_start, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    next(); reset = 1'b0;
    @(negedge clk);
    check("rst_wb_data", {wb_hi, wb_lo, wb_rob_ptr, wb_hilo_ptr}, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);
    next();

    // Unsigned 100/7 with a 3-cycle divider.
    send(32'd100, 32'd7, 1'b0, 5, 1);
    @(negedge clk); check("t1_accept", in_ready, 1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    check("t1_div_start", div_start, 1);
    check("t1_payload", {div_srcA, div_srcB, div_signed, div_rob_ptr, div_hilo_ptr},
          {32'd100, 32'd7, 1'b0, 6'd5, 2'd1});
    wait_complete("t1_complete");
    check("t1_wb_not_yet", wb_valid, 0);
    next(); @(negedge clk);
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_lo", wb_lo, 14);
    check("t1_wb_hi", wb_hi, 2);
    check("t1_wb_tags", {wb_rob_ptr, wb_hilo_ptr}, {6'd5, 2'd1});
    next();

    // Fill the FIFO while the divider is held off.
    dv_hold = 1'b1; dv_lat_min = 1; dv_lat_max = 4;
    for (int k = 0; k < 5; k++) begin
      send($urandom, $urandom_range(50, 1), 1'b0, 10 + k, k);
      @(negedge clk);
      if (k < 4) begin check("t2_accept", in_ready, 1); next(); end
      else check("t2_full", in_ready, 0);
    end
    next(); dv_hold = 1'b0;
    @(negedge clk);
    check("t2_launch", div_start, 1);
    check("t2_still_full", in_ready, 0);
    next(); @(negedge clk);
    check("t2_fifth_accepted", in_ready, 1);
    next(); in_valid = 1'b0;
    @(negedge clk);
    wait_drain("t2_drain");
    next();

    // Flush three cycles after launch with a second uop queued behind it.
    dv_lat_min = 8; dv_lat_max = 8;
    send(32'd77, 32'd5, 1'b0, 20, 2);
    @(negedge clk); next();
    send(32'd99, 32'd4, 1'b0, 21, 3);
    @(negedge clk); check("t3_div_start", div_start, 1);
    next(); in_valid = 1'b0;
    next(); next();
    flush = 1'b1; send(32'd12, 32'd3, 1'b0, 22, 0);
    @(negedge clk); check("t3_flush_drops_input", in_ready, 0);
    next(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); check("t3_busy_draining", busy, 1);
    check("t3_no_relaunch", div_start, 0);
    wait_complete("t3_complete");
    check("t3_busy_at_complete", busy, 1);
    next(); @(negedge clk);
    check("t3_no_wb", wb_valid, 0);
    check("t3_busy_fall", busy, 0);
    next();

    // Writeback backpressure: result held, queued uop must not launch.
    dv_lat_min = 2; dv_lat_max = 2; wb_ack = 1'b0;
    send(32'd1000, 32'd33, 1'b0, 30, 1);
    @(negedge clk); next();
    send(32'hFFFF_FF9C, 32'd7, 1'b1, 31, 2);
    @(negedge clk); next(); in_valid = 1'b0;
    @(negedge clk);
    wait_wb("t4_wb_valid");
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", wb_valid, 1);
      check("t4_hold_no_launch", div_start, 0);
      next(); @(negedge clk);
    end
    next(); wb_ack = 1'b1;
    @(negedge clk); check("t4_ack_rob", wb_rob_ptr, 30);
    next(); @(negedge clk);
    check("t4_launch_after_ack", div_start, 1);
    check("t4_launch_rob", div_rob_ptr, 31);
    wait_drain("t4_drain");
    next();

    // Flush coincident with div_complete.
    dv_lat_min = 4; dv_lat_max = 4;
    send(32'd500, 32'd9, 1'b0, 40, 0);
    @(negedge clk); next(); in_valid = 1'b0;
    @(negedge clk);
    wait_fire("t5a_fire");
    next(); flush = 1'b1;
    @(negedge clk); check("t5a_busy_in_flight", busy, 1);
    next(); flush = 1'b0;
    @(negedge clk);
    check("t5a_no_wb", wb_valid, 0);
    check("t5a_idle", busy, 0);
    next(); @(negedge clk); check("t5a_no_wb_later", wb_valid, 0);
    next();

    // Flush coincident with wb_ack.
    dv_lat_min = 2; dv_lat_max = 2; wb_ack = 1'b0;
    send(32'd64, 32'd8, 1'b0, 41, 3);
    @(negedge clk); next(); in_valid = 1'b0;
    @(negedge clk);
    wait_wb("t5b_wb_valid");
    next(); flush = 1'b1; wb_ack = 1'b1;
    @(negedge clk);
    next(); flush = 1'b0;
    @(negedge clk);
    check("t5b_no_wb", wb_valid, 0);
    check("t5b_idle", busy, 0);
    next();

    // Reset while the divider is busy.
    dv_lat_min = 8; dv_lat_max = 8;
    send(32'd4321, 32'd10, 1'b0, 50, 1);
    @(negedge clk); next(); in_valid = 1'b0;
    @(negedge clk); check("t6_div_start", div_start, 1);
    next(); next(); reset = 1'b1;
    @(negedge clk);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_outputs", {div_start, wb_valid, busy}, 0);
    next(); reset = 1'b0;
    @(negedge clk);
    check("t6_post_rst_ctrl", {wb_valid, busy}, 0);
    check("t6_post_rst_data", {wb_hi, wb_lo, wb_rob_ptr, wb_hilo_ptr}, 0);
    next();
    base = n_retired;
    dv_lat_min = 3; dv_lat_max = 3;
    send(32'hFFFF_FC18, 32'd33, 1'b1, 51, 2);
    @(negedge clk); next(); in_valid = 1'b0;
    @(negedge clk);
    wait_drain("t6_drain");
    check("t6_fresh_retired", n_retired - base, 1);
    next();

    // Random traffic with flushes, divider stalls and writeback backpressure.
    dv_lat_min = 1; dv_lat_max = 6;
    base = n_retired;
    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(1000, 1);
      sgn = $urandom_range(1, 0);
      if (b == 0) b = 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
      send(a, b, sgn, $urandom_range(63, 0), $urandom_range(3, 0));
      in_valid = $urandom_range(1, 0);
      flush = ($urandom_range(39, 0) == 0);
      wb_ack = ($urandom_range(3, 0) != 0);
      dv_hold = ($urandom_range(4, 0) == 0);
      next();
    end
    in_valid = 1'b0; flush = 1'b0; wb_ack = 1'b1; dv_hold = 1'b0;
    @(negedge clk);
    wait_drain("rand_drain");
    if (n_retired - base < 20) begin
      checks++; failures++;
      $display("FAIL rand_activity: got %0d retired expected at least 20", n_retired - base);
    end else checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
